// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
// Shares one wait-state ROM port between an instruction-fetch requester (F)
// and a data-read requester (D). Ties are broken round-robin. Each access holds
// CE/OE low for WAIT_CYCLES cycles, returns the sampled word with a one-cycle
// ack, then holds CE/OE high for RECOVER_CYCLES so the ROM wait counter re-arms.
module rom_access_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 16,
    parameter int WAIT_CYCLES    = 7,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              rom_ce_n,
    output logic              rom_oe_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam logic       GNT_F        = 1'b0;
    localparam logic       GNT_D        = 1'b1;
    localparam logic [3:0] WAIT_LAST    = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYCLES - 1);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                last_grant_q;
    logic                grant_q;
    logic                ce_n_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                f_ack_q;
    logic                d_ack_q;
    logic [DATA_W-1:0]   f_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                busy_q;

    logic                grant_d;
    logic [ADDR_W-1:0]   grant_addr_d;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        grant_d = GNT_F;
        if (f_req && d_req) begin
            grant_d = ~last_grant_q;
        end else if (d_req) begin
            grant_d = GNT_D;
        end else begin
            grant_d = GNT_F;
        end
    end

    // Address of the requester that would be granted at the next edge
    always_comb begin
        grant_addr_d = f_addr;
        if (grant_d == GNT_D) begin
            grant_addr_d = d_addr;
        end else begin
            grant_addr_d = f_addr;
        end
    end

    // Access sequencer: IDLE -> ACCESS (CE/OE low) -> RECOVER (CE/OE high), all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= GNT_D;
            grant_q      <= GNT_F;
            ce_n_q       <= 1'b1;
            addr_q       <= '0;
            f_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            // acks are single-cycle pulses unless re-armed below
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (f_req || d_req) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        addr_q       <= grant_addr_d;
                        ce_n_q       <= 1'b0;
                        cnt_q        <= 4'd0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ACCESS;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // rom_addr stays frozen here; requester address changes are ignored
                    if (cnt_q == WAIT_LAST) begin
                        if (grant_q == GNT_D) begin
                            d_rdata_q <= rom_data;
                            d_ack_q   <= 1'b1;
                        end else begin
                            f_rdata_q <= rom_data;
                            f_ack_q   <= 1'b1;
                        end
                        ce_n_q  <= 1'b1;
                        cnt_q   <= 4'd0;
                        state_q <= ST_RECOVER;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_q == RECOVER_LAST) begin
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 4'd0;
                    ce_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // CE and OE come from one register so they can never diverge
    assign rom_ce_n = ce_n_q;
    assign rom_oe_n = ce_n_q;
    assign rom_addr = addr_q;
    assign f_ack    = f_ack_q;
    assign d_ack    = d_ack_q;
    assign f_rdata  = f_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: default instance (7 wait, 1 recover)
// with a wait-counting ROM model, plus a 1-wait/3-recover instance.
module tb_rom_access_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int WAIT1 = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;

    // default instance
    logic          f_req = 1'b0, d_req = 1'b0;
    logic [AW-1:0] f_addr = 12'h000, d_addr = 12'h000;
    logic          f_ack, d_ack, rom_ce_n, rom_oe_n, busy;
    logic [DW-1:0] f_rdata, d_rdata;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = 16'hBAD0;

    // short-wait instance
    logic          f_req2 = 1'b0, d_req2 = 1'b0;
    logic [AW-1:0] f_addr2 = 12'h000, d_addr2 = 12'h000;
    logic          f_ack2, d_ack2, rom_ce_n2, rom_oe_n2, busy2;
    logic [DW-1:0] f_rdata2, d_rdata2;
    logic [AW-1:0] rom_addr2;
    logic [DW-1:0] rom_data2 = 16'hBAD1;

    int tests = 0;
    int fails = 0;
    int low_run1 = 0;
    int both_ack_cnt = 0;
    int ce_oe_diff = 0;

    always #5 clk = ~clk;

    rom_access_arbiter u_dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rdata(d_rdata),
        .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy)
    );

    rom_access_arbiter #(.WAIT_CYCLES(1), .RECOVER_CYCLES(3)) u_dut2 (
        .clk(clk), .reset(reset),
        .f_req(f_req2), .f_addr(f_addr2), .f_ack(f_ack2), .f_rdata(f_rdata2),
        .d_req(d_req2), .d_addr(d_addr2), .d_ack(d_ack2), .d_rdata(d_rdata2),
        .rom_ce_n(rom_ce_n2), .rom_oe_n(rom_oe_n2), .rom_addr(rom_addr2),
        .rom_data(rom_data2), .busy(busy2)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        case (a)
            12'h005: rom_word = 16'hA5A5;
            12'h006: rom_word = 16'h6666;
            12'h010: rom_word = 16'h1111;
            12'h020: rom_word = 16'h2222;
            default: rom_word = {4'h0, a};
        endcase
    endfunction

    // ROM models: the default ROM only drives valid data once CE has been low WAIT1 cycles;
    // the short-wait ROM is valid one half-cycle after CE falls. Also watches protocol invariants.
    always @(negedge clk) begin
        if (!rom_ce_n) begin
            low_run1 <= low_run1 + 1;
            rom_data <= (low_run1 + 1 >= WAIT1) ? rom_word(rom_addr) : 16'hBAD0;
        end else begin
            low_run1 <= 0;
            rom_data <= 16'hBAD0;
        end
        rom_data2 <= (!rom_ce_n2) ? rom_word(rom_addr2) : 16'hBAD1;
        if ((f_ack && d_ack) || (f_ack2 && d_ack2)) both_ack_cnt <= both_ack_cnt + 1;
        if ((rom_ce_n !== rom_oe_n) || (rom_ce_n2 !== rom_oe_n2)) ce_oe_diff <= ce_oe_diff + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int low, ack_at, n_f, n_d, n, hi, idle_cnt;
        int cyc[4];
        logic who[4];
        logic [AW-1:0] addr_seen;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_ce_n", {31'd0, rom_ce_n}, 32'd1);
        check("rst_oe_n", {31'd0, rom_oe_n}, 32'd1);
        check("rst_addr", {20'd0, rom_addr}, 32'h000);
        check("rst_acks", {30'd0, f_ack, d_ack}, 32'd0);
        check("rst_rdata", {f_rdata, d_rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- single fetch from 0x005 ----------------
        // i=0 is the IDLE cycle in which the request is first visible
        f_addr = 12'h005; f_req = 1'b1;
        low = 0; ack_at = -1; n_f = 0; n_d = 0; addr_seen = 12'h000;
        for (int i = 0; i < 20; i++) begin
            if (!rom_ce_n) low++;
            if (i == 1) addr_seen = rom_addr;
            if (d_ack) n_d++;
            if (f_ack) begin
                n_f++;
                if (ack_at < 0) ack_at = i;
                f_req = 1'b0;
            end
            tick();
        end
        check("t1_ce_low_cycles", low, 7);
        check("t1_rom_addr", {20'd0, addr_seen}, 32'h005);
        check("t1_ack_latency", ack_at, 8);
        check("t1_f_ack_count", n_f, 1);
        check("t1_d_ack_count", n_d, 0);
        check("t1_f_rdata", {16'd0, f_rdata}, 32'hA5A5);

        // ---------------- simultaneous requests alternate ----------------
        reset = 1'b1; tick(); reset = 1'b0; tick();
        f_addr = 12'h010; d_addr = 12'h020; f_req = 1'b1; d_req = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            if (f_ack || d_ack) begin
                who[n] = d_ack;
                cyc[n] = i;
                n++;
                if (n == 4) begin
                    f_req = 1'b0; d_req = 1'b0;
                end
            end
            tick();
        end
        f_req = 1'b0; d_req = 1'b0;
        check("t2_ack_count", n, 4);
        check("t2_order", {28'd0, who[0], who[1], who[2], who[3]}, 32'b0101);
        check("t2_first_latency", cyc[0], 8);
        check("t2_gap01", cyc[1] - cyc[0], 9);
        check("t2_gap12", cyc[2] - cyc[1], 9);
        check("t2_gap23", cyc[3] - cyc[2], 9);
        check("t2_f_rdata", {16'd0, f_rdata}, 32'h1111);
        check("t2_d_rdata", {16'd0, d_rdata}, 32'h2222);
        for (int i = 0; i < 5; i++) tick();

        // ---------------- data requester held for three accesses ----------------
        d_addr = 12'h020; d_req = 1'b1;
        n = 0; hi = 0; low = 0; idle_cnt = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            if (d_ack) begin
                cyc[n] = i;
                n++;
                if (n == 3) d_req = 1'b0;
            end
            // window from the first ack up to (not including) the third
            if (n == 1 || n == 2) begin
                if (rom_ce_n) hi++; else low++;
                if (!busy) idle_cnt++;
            end
            tick();
        end
        check("t3_ack_count", n, 3);
        check("t3_period_a", cyc[1] - cyc[0], 9);
        check("t3_period_b", cyc[2] - cyc[1], 9);
        // per period: RECOVER cycle + IDLE cycle high, 7 cycles low
        check("t3_ce_high_cycles", hi, 4);
        check("t3_ce_low_cycles", low, 14);
        check("t3_busy_low_cycles", idle_cnt, 2);
        for (int i = 0; i < 5; i++) tick();

        // ---------------- address change during ACCESS is ignored ----------------
        f_addr = 12'h005; f_req = 1'b1;
        ack_at = -1; addr_seen = 12'h000;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) f_addr = 12'h006;
            if (i == 5) addr_seen = rom_addr;
            if (f_ack) begin
                if (ack_at < 0) ack_at = i;
                f_req = 1'b0;
            end
            tick();
        end
        check("t4_addr_frozen", {20'd0, addr_seen}, 32'h005);
        check("t4_ack_latency", ack_at, 8);
        check("t4_f_rdata", {16'd0, f_rdata}, 32'hA5A5);

        // ---------------- reset in the 4th ACCESS cycle ----------------
        f_addr = 12'h010; f_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t5_in_access", {31'd0, rom_ce_n}, 32'd0);
        reset = 1'b1;
        #1;
        check("t5_async_ce_n", {31'd0, rom_ce_n}, 32'd1);
        check("t5_async_oe_n", {31'd0, rom_oe_n}, 32'd1);
        check("t5_async_busy", {31'd0, busy}, 32'd0);
        check("t5_no_ack", {31'd0, f_ack}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        low = 0; ack_at = -1; n_f = 0;
        for (int i = 0; i < 20; i++) begin
            if (!rom_ce_n) low++;
            if (f_ack) begin
                n_f++;
                if (ack_at < 0) ack_at = i;
                f_req = 1'b0;
            end
            tick();
        end
        check("t5_ce_low_cycles", low, 7);
        check("t5_ack_latency", ack_at, 8);
        check("t5_ack_count", n_f, 1);
        check("t5_f_rdata", {16'd0, f_rdata}, 32'h1111);

        // ---------------- short-wait instance ----------------
        f_addr2 = 12'h006; f_req2 = 1'b1;
        n = 0; n_d = 0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            if (d_ack2) n_d++;
            if (f_ack2) begin
                cyc[n] = i;
                n++;
                if (n == 2) f_req2 = 1'b0;
            end
            tick();
        end
        f_req2 = 1'b0;
        check("t6_ack_count", n, 2);
        check("t6_ack_latency", cyc[0], 2);
        check("t6_period", cyc[1] - cyc[0], 5);
        check("t6_f_rdata", {16'd0, f_rdata2}, 32'h6666);
        check("t6_d_ack_count", n_d, 0);
        for (int i = 0; i < 5; i++) tick();

        // ---------------- invariants over the whole run ----------------
        check("no_simultaneous_ack", both_ack_cnt, 0);
        check("ce_oe_together", ce_oe_diff, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
